dat_mem_stack: RTL



---
 rtl/dat_mem_stack.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dat_mem_stack.sv
// dat_mem_stack
// Data memory with a hardware stack pointer, placed between the core
// datapath and data storage. One request per cycle: LOAD, STORE, PUSH, POP.
// After reset the whole array is optionally swept to zero (one word per
// cycle); requests are refused while the sweep runs.
//
// Ports:
//   Clk        clock, all state changes on the rising edge
//   Reset      asynchronous active-high reset
//   Valid      request strobe, honoured only when Ready=1
//   Op         00 LOAD, 01 STORE, 10 PUSH, 11 POP
//   Addr       load/store address
//   DataIn     store/push data
//   DataOut    combinational read data
//   Ready      requests accepted (= ~Busy)
//   Busy       clear sweep in progress
//   SP         stack pointer, points at the next free slot (grows downward)
//   Empty      SP == STACK_TOP
//   Full       SP == STACK_LIMIT-1
//   Overflow   one-cycle pulse after a rejected push
//   Underflow  one-cycle pulse after a rejected pop
module dat_mem_stack #(
  parameter int W              = 8,
  parameter int AW             = 8,
  parameter int STACK_TOP      = 255,
  parameter int STACK_LIMIT    = 192,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Valid,
  input  logic [1:0]    Op,
  input  logic [AW-1:0] Addr,
  input  logic [W-1:0]  DataIn,
  output logic [W-1:0]  DataOut,
  output logic          Ready,
  output logic          Busy,
  output logic [AW-1:0] SP,
  output logic          Empty,
  output logic          Full,
  output logic          Overflow,
  output logic          Underflow
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  localparam logic [AW-1:0] SP_EMPTY = AW'(STACK_TOP);
  localparam logic [AW-1:0] SP_FULL  = AW'(STACK_LIMIT - 1);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  // Storage has no reset; the clear sweep is what initialises it.
  logic [W-1:0] core [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] sp_q, sp_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] sp_plus1;
  logic          empty, full;

  assign empty    = (sp_q == SP_EMPTY);
  assign full     = (sp_q == SP_FULL);
  // Only used when the stack is non-empty, so SP+1 never wraps.
  assign sp_plus1 = sp_q + AW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = Addr;
    wr_data = DataIn;
    DataOut = core[Addr];
    Busy    = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        Busy    = 1'b1;
        DataOut = '0;
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (Valid) begin
          case (Op)
            OP_LOAD: begin
            end
            OP_STORE: begin
              wr_en = 1'b1;
            end
            OP_PUSH: begin
              if (full) begin
                ovf_d = 1'b1;
              end else begin
                wr_en   = 1'b1;
                wr_addr = sp_q;
                sp_d    = sp_q - AW'(1);
              end
            end
            OP_POP: begin
              if (empty) begin
                unf_d   = 1'b1;
                DataOut = '0;
              end else begin
                DataOut = core[sp_plus1];
                sp_d    = sp_plus1;
              end
            end
            default: begin
            end
          endcase
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      sp_q    <= SP_EMPTY;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      core[wr_addr] <= wr_data;
    end
  end

  assign Ready     = ~Busy;
  assign SP        = sp_q;
  assign Empty     = empty;
  assign Full      = full;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule
